// File: rtl/exec_writeback_unit_if.sv
// exec_writeback_unit_if: fetch/decode <-> execute/writeback handshake and register-file write bus.
interface exec_writeback_unit_if;
   logic        start;
   logic [15:0] instruction;
   logic [15:0] regbus1;
   logic [15:0] regbus2;
   logic [1:0]  flags;
   logic [15:0] regbus3;
   logic        regbus3writeenable;
   logic [1:0]  flagsbus;
   logic        flagswriteenable;
   logic        busy;
   logic        done;
   modport master (
      output start, instruction, regbus1, regbus2, flags,
      input  regbus3, regbus3writeenable, flagsbus, flagswriteenable, busy, done
   );
   modport slave (
      input  start, instruction, regbus1, regbus2, flags,
      output regbus3, regbus3writeenable, flagsbus, flagswriteenable, busy, done
   );
endinterface

// File: rtl/exec_writeback_unit.sv
// exec_writeback_unit: executes one ALU instruction and drives the register/flags write buses for one cycle.
// Define EXEC_MUL_EN to build the 16-cycle shift-add multiplier for opcode B; otherwise B is a NOP.
module exec_writeback_unit (
   input logic                  clk,
   input logic                  reset,
   exec_writeback_unit_if.slave bus
);
`ifdef EXEC_MUL_EN
   typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
`else
   typedef enum logic [1:0] {IDLE, WB} state_t;
`endif
   state_t      r_state, w_next;
   logic [15:0] r_res;
   logic [1:0]  r_flags;
   logic        r_rwe, r_fwe;
   logic [3:0]  w_op;
   logic [15:0] w_a, w_b, w_res;
   logic        w_c, w_rwe, w_fwe, w_mul, w_accept, w_unused;
`ifdef EXEC_MUL_EN
   logic [31:0] r_acc, r_mcand, w_acc_nx;
   logic [15:0] r_mplier;
   logic [3:0]  r_cnt;
`endif
   assign w_op     = bus.instruction[15:12];
   assign w_a      = bus.regbus1;
   assign w_b      = bus.regbus2;
   assign w_accept = bus.start & (r_state == IDLE);
   assign w_unused = ^bus.instruction[3:0];
   always_comb begin
      w_res = 16'h0000;
      w_c   = 1'b0;
      w_rwe = 1'b0;
      w_fwe = 1'b0;
      w_mul = 1'b0;
      case (w_op)
         4'h0: begin w_res = w_b; w_rwe = 1'b1; end
         4'h1: begin {w_c, w_res} = {1'b0, w_a} + {1'b0, w_b}; w_rwe = 1'b1; w_fwe = 1'b1; end
         4'h2: begin {w_c, w_res} = {1'b0, w_a} + {1'b0, w_b} + {16'h0000, bus.flags[1]}; w_rwe = 1'b1; w_fwe = 1'b1; end
         4'h3, 4'h7: begin w_res = w_a - w_b; w_c = w_a < w_b; w_rwe = (w_op == 4'h3); w_fwe = 1'b1; end
         4'h4: begin w_res = w_a & w_b; w_rwe = 1'b1; w_fwe = 1'b1; end
         4'h5: begin w_res = w_a | w_b; w_rwe = 1'b1; w_fwe = 1'b1; end
         4'h6: begin w_res = w_a ^ w_b; w_rwe = 1'b1; w_fwe = 1'b1; end
         4'h8: begin w_res = {8'h00, bus.instruction[11:4]}; w_rwe = 1'b1; end
         4'h9: begin {w_c, w_res} = {w_a, 1'b0}; w_rwe = 1'b1; w_fwe = 1'b1; end
         4'hA: begin {w_res, w_c} = {1'b0, w_a}; w_rwe = 1'b1; w_fwe = 1'b1; end
`ifdef EXEC_MUL_EN
         4'hB: begin w_mul = 1'b1; w_rwe = 1'b1; w_fwe = 1'b1; end
`endif
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
`ifdef EXEC_MUL_EN
         IDLE:    w_next = w_accept ? (w_mul ? MUL : WB) : IDLE;
         MUL:     w_next = (r_cnt == 4'hF) ? WB : MUL;
`else
         IDLE:    w_next = w_accept ? WB : IDLE;
`endif
         default: w_next = IDLE;
      endcase
   end
`ifdef EXEC_MUL_EN
   assign w_acc_nx = r_mplier[0] ? r_acc + r_mcand : r_acc;
`endif
   // Result/flag registers only move for the buses the opcode actually writes, so skipped buses hold their value.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_res    <= 16'h0000;
         r_flags  <= 2'b00;
         r_rwe    <= 1'b0;
         r_fwe    <= 1'b0;
`ifdef EXEC_MUL_EN
         r_acc    <= 32'h0;
         r_mcand  <= 32'h0;
         r_mplier <= 16'h0;
         r_cnt    <= 4'h0;
`endif
      end else begin
         if (w_accept) begin
            r_rwe <= w_rwe;
            r_fwe <= w_fwe;
            if (w_rwe && !w_mul) r_res <= w_res;
            if (w_fwe && !w_mul) r_flags <= {w_c, w_res == 16'h0000};
`ifdef EXEC_MUL_EN
            r_acc    <= 32'h0;
            r_mcand  <= {16'h0000, w_a};
            r_mplier <= w_b;
            r_cnt    <= 4'h0;
`endif
         end
`ifdef EXEC_MUL_EN
         if (r_state == MUL) begin
            r_acc    <= w_acc_nx;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 4'd1;
            if (r_cnt == 4'hF) begin
               r_res   <= w_acc_nx[15:0];
               r_flags <= {|w_acc_nx[31:16], w_acc_nx[15:0] == 16'h0000};
            end
         end
`endif
      end
   assign bus.regbus3            = r_res;
   assign bus.flagsbus           = r_flags;
   assign bus.busy               = (r_state != IDLE);
   assign bus.done               = (r_state == WB);
   assign bus.regbus3writeenable = bus.done & r_rwe;
   assign bus.flagswriteenable   = bus.done & r_fwe;
endmodule

// File: doc/exec_writeback_unit.md
# exec_writeback_unit

Execute/writeback stage sitting on the write side of the 16×16 register file.
- Consumes the Rx/Ry read values and current flags, executes one ALU instruction.
- Drives the register file's write bus (value, write enable) and flags write bus for exactly one cycle per instruction.
- Single-cycle ops complete in 1 cycle; multiply is a 16-iteration shift-add sequence.
- Upstream fetch/decode logic handshakes via start/busy/done.

## Interface
Parameters: none.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to execute instruction; accepted only when busy=0.
- instruction  in  16  [15:12] opcode, [11:4] imm8, [7:4] Ry, [3:0] Rx. Must be held stable from the start cycle through the done cycle, because the register file takes its write address from it.
- regbus1  in  16  Rx value (combinational read), sampled on accept.
- regbus2  in  16  Ry value, sampled on accept.
- flags  in  2  current flags: [1] carry/borrow, [0] zero; sampled on accept.
- regbus3  out  16  result value to register file.
- regbus3writeenable  out  1  one-cycle register write strobe.
- flagsbus  out  2  new flags, same bit order as flags.
- flagswriteenable  out  1  one-cycle flags write strobe.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse; coincides with write strobes.

## Operation
- States: IDLE, MUL, WB.
  - IDLE + start → WB, or MUL for opcode B.
  - MUL → WB after 16 iterations.
  - WB → IDLE unconditionally.
- Operands and flags are captured on the accept edge and computed into result/flag registers. Outputs are registered: regbus3 and flagsbus hold the last result and change only when WB is entered.
- In WB: done=1, regbus3writeenable and flagswriteenable per opcode. All strobes are 0 in every other state.
- Opcodes (C = carry, Z = zero, Z = (16-bit result == 0)):
  - 0 MOV: Rx←Ry; reg write only.
  - 1 ADD: Rx+Ry; C = bit 16; reg and flags write.
  - 2 ADC: Rx+Ry+C_in; C = bit 16; reg and flags write.
  - 3 SUB: Rx−Ry; C = borrow (Rx<Ry unsigned); reg and flags write.
  - 4 AND, 5 OR, 6 XOR: C=0; reg and flags write.
  - 7 CMP: SUB flags only; regbus3writeenable=0.
  - 8 LDI: Rx←{8'h00, imm8}; reg write only.
  - 9 SHL: Rx<<1, C = old bit 15. A SHR: logical Rx>>1, C = old bit 0. Both: reg and flags write.
  - B MUL: Rx←low 16 bits of Rx×Ry (unsigned); C = (high 16 ≠ 0); reg and flags write.
  - C–F: NOP; WB with done=1, no strobes.
- MUL: 32-bit accumulator, multiplicand shifted left and multiplier shifted right each cycle, exactly 16 cycles regardless of operand values.
- start while busy=1 (including during the WB cycle) is ignored, not queued.

## Timing
- Reset (asserted asynchronously): state IDLE; regbus3=0, flagsbus=0, all strobes=0, busy=0, done=0, internal accumulators cleared. Reset mid-MUL or during WB aborts with no write issued. First accept is possible on the first edge after reset is released.
- Accept at edge E0 (start=1, busy=0).
  - Non-MUL: WB during cycle after E0 (latency 1); register file commits at E1.
  - MUL: MUL state for 16 cycles, WB in the 17th cycle after E0.
- Earliest next accept is the edge after WB: single-cycle ops sustain 1 instruction per 2 cycles; MUL 1 per 18.
- busy rises the cycle after accept, falls the cycle after done.

## Configuration
- EXEC_MUL_EN defined: opcode B executes as above; MUL state and shift-add datapath present.
- EXEC_MUL_EN undefined: no MUL state or multiplier logic; opcode B decodes as NOP (latency 1, done only, no strobes).

## Test plan
- Reset, then ADD with Rx=16'hFFFF, Ry=16'h0001 → one cycle later regbus3=16'h0000, flagsbus=2'b11, both strobes and done high for exactly 1 cycle.
- ADC with flags=2'b10, Rx=16'h0003, Ry=16'h0004 → regbus3=16'h0008, flagsbus=2'b00; then CMP with Rx=16'h0002, Ry=16'h0005 → flagsbus=2'b10, regbus3writeenable=0.
- MUL (EXEC_MUL_EN) with Rx=16'h0100, Ry=16'h0101 → done at cycle 17, regbus3=16'h0100, flagsbus=2'b10. Rx=16'h0003, Ry=16'h0007 → 16'h0015, flagsbus=2'b00. busy=1 throughout; start pulses during busy are ignored.
- LDI with instruction=16'h8A53 → regbus3=16'h00A5 written, flagswriteenable=0; opcode F → done only, no strobes.
- Drop reset at cycle 8 of a MUL → outputs 0 immediately, no strobe ever issued; next ADD after release completes normally.
- Build without EXEC_MUL_EN, opcode B → done at cycle 1, no strobes, regbus3 unchanged from prior value.
